// File: rtl/dtw_pkg.sv
// Shared state encodings and default sizing for the DTW reference stream memory.
// Banks are written by a streaming loader and replayed by a streaming reader.
package dtw_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_PTR_WID   = 18;
  localparam int DEF_NUM_BANKS = 2;

  typedef enum logic {
    L_IDLE = 1'b0,
    L_LOAD = 1'b1
  } l_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_RUN   = 2'd1,
    R_DRAIN = 2'd2
  } r_state_t;

endpackage

// File: rtl/dtw_ref_bank.sv
// One reference bank: simple dual-port RAM, one write port, one registered read port.
// Storage is never reset; validity is tracked by the owner of the bank.
module dtw_ref_bank
  import dtw_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PTR_WID = DEF_PTR_WID
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [PTR_WID-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  input  logic [PTR_WID-1:0] rd_addr,
  output logic [WIDTH-1:0]   rd_data
);

  logic [WIDTH-1:0] mem [2**PTR_WID];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dtw_ref_stream_mem.sv
// Multi-bank reference sample store: streaming load per bank, streaming replay with a
// 2-entry skid buffer so the read side tolerates any out_ready pattern at full rate.
module dtw_ref_stream_mem
  import dtw_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PTR_WID   = DEF_PTR_WID,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  localparam int BANK_WID = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [WIDTH-1:0]    ld_data,
  input  logic                ld_last,
  input  logic [BANK_WID-1:0] ld_bank,
  input  logic                rd_start,
  input  logic [BANK_WID-1:0] rd_bank,
  input  logic [PTR_WID:0]    rd_len,
  output logic                rd_busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_last,
  output logic [NUM_BANKS-1:0] bank_loaded,
  output logic                ld_overflow,
  output logic                rd_done
);

  localparam logic [PTR_WID:0] ONE = {{PTR_WID{1'b0}}, 1'b1};

  // ---------------- load side ----------------
  l_state_t            l_state;
  logic [BANK_WID-1:0] l_bank;
  logic [PTR_WID:0]    l_cnt;
  logic [PTR_WID:0]    bank_len [NUM_BANKS];

  logic [BANK_WID-1:0] tgt_bank;
  logic                ld_fire;
  logic                l_full;
  logic                wr_en;
  logic [PTR_WID-1:0]  wr_addr;
  logic [PTR_WID:0]    l_cnt_nxt;

  // ---------------- read side ----------------
  r_state_t            r_state;
  logic [BANK_WID-1:0] r_bank;
  logic [PTR_WID:0]    r_len;
  logic [PTR_WID:0]    r_addr;
  logic                inflight;
  logic                pend_last;
  logic [1:0]          b_cnt;
  logic [1:0]          b_last;
  logic [WIDTH-1:0]    b_dat [2];

  logic                start_ok;
  logic [PTR_WID:0]    sel_len;
  logic [PTR_WID:0]    eff_len;
  logic                pop;
  logic [2:0]          occ;
  logic                issue;
  logic                issue_last;
  logic [BANK_WID-1:0] issue_bank;
  logic [PTR_WID-1:0]  issue_addr;
  logic [1:0]          keep;
  logic                wr_slot;
  logic [WIDTH-1:0]    bank_q [NUM_BANKS];
  logic [WIDTH-1:0]    rd_q;

  assign tgt_bank  = (l_state == L_LOAD) ? l_bank : ld_bank;
  assign ld_ready  = !(rd_busy && (tgt_bank == r_bank));
  assign ld_fire   = ld_valid && ld_ready;
  assign l_full    = l_cnt[PTR_WID];
  // Beats past the bank depth are accepted but never written, so addresses do not wrap.
  assign wr_en     = ld_fire && ((l_state == L_IDLE) || !l_full);
  assign wr_addr   = (l_state == L_IDLE) ? '0 : l_cnt[PTR_WID-1:0];
  assign l_cnt_nxt = l_full ? l_cnt : (l_cnt + ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      l_state     <= L_IDLE;
      l_bank      <= '0;
      l_cnt       <= '0;
      ld_overflow <= 1'b0;
      bank_loaded <= '0;
      for (int i = 0; i < NUM_BANKS; i++) bank_len[i] <= '0;
    end else if (ld_fire) begin
      if (l_state == L_IDLE) begin
        l_bank <= ld_bank;
        if (ld_last) begin
          bank_loaded[ld_bank] <= 1'b1;
          bank_len[ld_bank]    <= ONE;
        end else begin
          bank_loaded[ld_bank] <= 1'b0;
          l_cnt                <= ONE;
          l_state              <= L_LOAD;
        end
      end else begin
        if (l_full) ld_overflow <= 1'b1;
        l_cnt <= l_cnt_nxt;
        if (ld_last) begin
          bank_loaded[l_bank] <= 1'b1;
          bank_len[l_bank]    <= l_cnt_nxt;
          l_state             <= L_IDLE;
        end
      end
    end
  end

  always_comb begin
    sel_len = bank_len[rd_bank];
    eff_len = '0;
    if (bank_loaded[rd_bank]) eff_len = (rd_len < sel_len) ? rd_len : sel_len;
  end

  assign start_ok  = rd_start && !rd_busy && (r_state == R_IDLE);
  assign out_valid = (b_cnt != 2'd0);
  assign out_data  = b_dat[0];
  assign out_last  = b_last[0];
  assign pop       = out_valid && out_ready;
  assign rd_q      = bank_q[r_bank];

  // Words already buffered plus the one landing from the RAM, minus this cycle's pop,
  // must leave a free slot for anything issued now.
  assign occ = {1'b0, b_cnt} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_bank = r_bank;
    issue_addr = r_addr[PTR_WID-1:0];
    if (r_state == R_IDLE) begin
      issue_bank = rd_bank;
      issue_addr = '0;
      issue      = start_ok && (eff_len != '0);
      issue_last = (eff_len == ONE);
    end else if (r_state == R_RUN) begin
      issue      = (occ <= 3'd1);
      issue_last = ((r_addr + ONE) == r_len);
    end
  end

  assign keep    = b_cnt - {1'b0, pop};
  assign wr_slot = (keep != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      r_bank    <= '0;
      r_len     <= '0;
      r_addr    <= '0;
      rd_busy   <= 1'b0;
      rd_done   <= 1'b0;
      inflight  <= 1'b0;
      pend_last <= 1'b0;
      b_cnt     <= 2'd0;
      b_last    <= 2'b00;
    end else begin
      rd_done   <= 1'b0;
      inflight  <= issue;
      pend_last <= issue && issue_last;
      b_cnt     <= keep + {1'b0, inflight};
      if (pop) b_last[0] <= b_last[1];
      if (inflight) b_last[wr_slot] <= pend_last;
      case (r_state)
        R_IDLE: begin
          if (start_ok) begin
            r_bank <= rd_bank;
            r_len  <= eff_len;
            if (eff_len == '0) begin
              rd_done <= 1'b1;
            end else begin
              rd_busy <= 1'b1;
              r_addr  <= ONE;
              r_state <= issue_last ? R_DRAIN : R_RUN;
            end
          end
        end
        R_RUN: begin
          if (issue) begin
            r_addr <= r_addr + ONE;
            if (issue_last) r_state <= R_DRAIN;
          end
        end
        R_DRAIN: begin
          if (pop && out_last) begin
            rd_done <= 1'b1;
            rd_busy <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Payload is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (pop) b_dat[0] <= b_dat[1];
    if (inflight) b_dat[wr_slot] <= rd_q;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    dtw_ref_bank #(
      .WIDTH   (WIDTH),
      .PTR_WID (PTR_WID)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_en && (tgt_bank == BANK_WID'(b))),
      .wr_addr (wr_addr),
      .wr_data (ld_data),
      .rd_en   (issue && (issue_bank == BANK_WID'(b))),
      .rd_addr (issue_addr),
      .rd_data (bank_q[b])
    );
  end

endmodule

// File: doc/dtw_ref_stream_mem.md
DTW_REF_STREAM_MEM -- requirements
Module: dtw_ref_stream_mem

Interface
REQ-001 SHALL have parameter WIDTH, default 16, reference sample width in bits.
REQ-002 SHALL have parameter PTR_WID, default 18, per-bank address width; bank depth = 2**PTR_WID.
REQ-003 SHALL have parameter NUM_BANKS, default 2, number of independent reference banks (power of two, >=2); BANK_WID = max(1, clog2(NUM_BANKS)).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-005 ld_valid in 1, load beat valid; ld_ready out 1, load beat accepted when both high; ld_data in WIDTH, sample; ld_last in 1, final beat of a load; ld_bank in BANK_WID, target bank, sampled on the first beat only.
REQ-006 rd_start in 1, one-cycle read request, honoured only when rd_busy=0; rd_bank in BANK_WID; rd_len in PTR_WID+1, sample count; rd_busy out 1.
REQ-007 out_valid out 1; out_ready in 1; out_data out WIDTH; out_last out 1, marks final sample of a read.
REQ-008 bank_loaded out NUM_BANKS, per-bank valid flag; ld_overflow out 1, sticky error flag; rd_done out 1, one-cycle completion pulse.

Function
REQ-009 Load FSM states SHALL be L_IDLE and L_LOAD; the first accepted beat latches ld_bank, writes address 0, and enters L_LOAD; each further accepted beat writes the next address; a beat with ld_last=1 returns the FSM to L_IDLE.
REQ-010 Completing a load SHALL set bank_loaded[bank]=1 and store a per-bank length = beats written (1..2**PTR_WID); the first beat of a new load SHALL clear bank_loaded[bank].
REQ-011 Beats beyond 2**PTR_WID in one load SHALL be accepted and dropped (no address wrap), SHALL set ld_overflow, and the stored length SHALL saturate at 2**PTR_WID.
REQ-012 ld_ready SHALL be 0 while the load's target bank (latched bank in L_LOAD, ld_bank in L_IDLE) equals the bank being read with rd_busy=1; otherwise ld_ready=1.
REQ-013 Read FSM states SHALL be R_IDLE, R_RUN and R_DRAIN; an honoured rd_start SHALL latch rd_bank and an effective length = min(rd_len, stored length of that bank) and set rd_busy.
REQ-014 An effective length of 0, or rd_start to a bank with bank_loaded=0, SHALL produce no output beats, pulse rd_done one cycle later, and return to R_IDLE.
REQ-015 R_RUN SHALL issue sequential addresses 0..len-1 to the bank; RAM read latency is 1 cycle; issued reads SHALL land in a 2-entry output buffer and issue SHALL stall when the buffer cannot accept the in-flight word, so no sample is lost or duplicated under any out_ready pattern.
REQ-016 First out_valid SHALL appear 2 cycles after rd_start when out_ready is held high; sustained throughput SHALL be one sample per cycle.
REQ-017 out_last SHALL accompany sample len-1; after the last issue the FSM SHALL enter R_DRAIN, and on the handshake of the out_last beat it SHALL pulse rd_done, clear rd_busy and return to R_IDLE.
REQ-018 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 A load and a read to different banks SHALL proceed concurrently without interaction in the same cycle.

Reset
REQ-020 Reset SHALL force L_IDLE, R_IDLE, ld_ready=1, rd_busy=0, out_valid=0, out_last=0, rd_done=0, ld_overflow=0, bank_loaded=0, all stored lengths=0, and empty the output buffer; out_data is don't-care.
REQ-021 Reset mid-load or mid-read SHALL abandon the operation; RAM contents need not be cleared but SHALL be unreadable until reloaded (bank_loaded=0).

Structure
REQ-022 State encodings (L_IDLE/L_LOAD, R_IDLE/R_RUN/R_DRAIN) and default parameter values SHALL live in the shared package dtw_pkg.
REQ-023 Each bank SHALL be an instance of sub-module dtw_ref_bank: simple dual-port block RAM, one write port, one registered read port, no reset on storage.

Verification
REQ-024 Load 8 samples 1..8 into bank 0, read rd_len=8 with out_ready=1 -> out_data 1..8 on consecutive cycles, first beat 2 cycles after rd_start, out_last on 8, rd_done once.
REQ-025 Same read with out_ready toggling 1,0,0,1 repeatedly -> exactly 1..8 in order, data stable during stalls.
REQ-026 Read bank 0 (len 8) while loading bank 1 and then bank 0 -> bank 1 beats accepted every cycle; bank 0 load sees ld_ready=0 until rd_done.
REQ-027 PTR_WID=3, load 10 beats -> ld_overflow=1, stored length 8, readback of addresses 0..7 = first 8 beats.
REQ-028 rd_len=20 on an 8-sample bank -> 8 beats; rd_start on an unloaded bank -> zero beats, rd_done one cycle later.
REQ-029 Assert rst during R_RUN with out_valid=1 -> next cycle out_valid=0, rd_busy=0, bank_loaded=0.
